// File: rtl/frankie_regcheck_pkg.sv
// Shared definitions for the Frankie register checker: FSM state encoding,
// fail codes reported on fail_code, and the watched channel numbering.
package frankie_regcheck_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_PASS = 2'b10,
        ST_FAIL = 2'b11
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE     = 2'b00,
        FC_TIMEOUT  = 2'b01,
        FC_MISMATCH = 2'b10
    } fail_code_t;

    localparam int CH_MARY    = 0;
    localparam int CH_SHELLEY = 1;
    localparam int CH_RA      = 2;
    localparam int CH_SP      = 3;

endpackage

// File: rtl/frankie_regcheck_table.sv
// Checkpoint table: DEPTH entries of {channel, expected value}, filled in
// order from entry 0, with an asynchronous read port at the run pointer.
module frankie_regcheck_table #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 4,
    parameter int DEPTH  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       we,
    input  logic [$clog2(NUM_CH)-1:0]  wr_ch,
    input  logic [DATA_W-1:0]          wr_value,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    output logic [$clog2(NUM_CH)-1:0]  rd_ch,
    output logic [DATA_W-1:0]          rd_value,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int ENT_W = CH_W + DATA_W;

    logic [ENT_W-1:0] mem [DEPTH];

    assign full = (count == (IDX_W+1)'(DEPTH));

    // Fill pointer: counts loaded entries, cleared by reset or clr.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (we && !full) begin
            count <= count + (IDX_W+1)'(1);
        end
    end

    // Entry storage: written at the fill pointer, contents need no reset.
    always_ff @(posedge clock) begin
        if (we && !full && !clr) begin
            mem[count[IDX_W-1:0]] <= {wr_ch, wr_value};
        end
    end

    assign {rd_ch, rd_value} = mem[rd_ptr];

endmodule

// File: rtl/frankie_regcheck.sv
// Frankie register checker top: FSM, per-checkpoint timeout timer, write
// comparator and run statistics around the checkpoint table.
// Optional build macro FRANKIE_REGCHECK_STRICT_EN: the first write to the
// active channel must carry the expected value, otherwise FAIL with the
// mismatch code. Without it, non-matching writes are simply ignored.
module frankie_regcheck
    import frankie_regcheck_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_CH  = 4,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       clr,
    input  logic                       ld_valid,
    input  logic [$clog2(NUM_CH)-1:0]  ld_ch,
    input  logic [DATA_W-1:0]          ld_value,
    output logic                       ld_ready,
    input  logic                       start,
    input  logic [NUM_CH-1:0]          wr_en,
    input  logic [NUM_CH*DATA_W-1:0]   wr_data,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [1:0]                 fail_code,
    output logic [$clog2(DEPTH)-1:0]   fail_idx,
    output logic [31:0]                cycles
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TMR_W = 16;

    state_t             state;
    state_t             state_nxt;
    fail_code_t         fail_code_reg;
    fail_code_t         fail_code_nxt;
    logic [IDX_W-1:0]   rd_ptr;
    logic [TMR_W-1:0]   timer;
    logic [IDX_W:0]     count;
    logic               full;
    logic [CH_W-1:0]    act_ch;
    logic [DATA_W-1:0]  act_value;
    logic               act_wr;
    logic [DATA_W-1:0]  act_data;
    logic               match;
    logic               is_last;
    logic               timed_out;
    logic               load_en;
    logic               run_init;
    logic               advance;

    frankie_regcheck_table #(
        .DATA_W (DATA_W),
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH)
    ) u_table (
        .clock    (clock),
        .reset    (reset),
        .clr      (clr),
        .we       (load_en),
        .wr_ch    (ld_ch),
        .wr_value (ld_value),
        .rd_ptr   (rd_ptr),
        .rd_ch    (act_ch),
        .rd_value (act_value),
        .count    (count),
        .full     (full)
    );

    // Only the active checkpoint's channel is looked at; other writes are noise.
    assign act_wr    = wr_en[act_ch];
    assign act_data  = wr_data[int'(act_ch)*DATA_W +: DATA_W];
    assign match     = act_wr && (act_data == act_value);
    assign is_last   = ((IDX_W+1)'(rd_ptr) + (IDX_W+1)'(1)) == count;
    assign timed_out = (timer == TMR_W'(TIMEOUT - 1));

    assign ld_ready  = (state == ST_IDLE) && !full;
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_PASS) || (state == ST_FAIL);
    assign pass      = (state == ST_PASS);
    assign fail_code = fail_code_reg;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control; clr overrides everything else.
    always_comb begin
        state_nxt     = state;
        fail_code_nxt = FC_NONE;
        load_en       = 1'b0;
        run_init      = 1'b0;
        advance       = 1'b0;
        if (clr) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        run_init  = 1'b1;
                        state_nxt = (count == '0) ? ST_PASS : ST_RUN;
                    end else if (ld_valid && ld_ready) begin
                        load_en = 1'b1;
                    end
                end
                ST_RUN: begin
                    if (match) begin
                        advance = 1'b1;
                        if (is_last) begin
                            state_nxt = ST_PASS;
                        end
                    end
`ifdef FRANKIE_REGCHECK_STRICT_EN
                    else if (act_wr) begin
                        state_nxt     = ST_FAIL;
                        fail_code_nxt = FC_MISMATCH;
                    end
`endif
                    else if (timed_out) begin
                        state_nxt     = ST_FAIL;
                        fail_code_nxt = FC_TIMEOUT;
                    end
                end
                default: begin
                    if (start) begin
                        run_init  = 1'b1;
                        state_nxt = (count == '0) ? ST_PASS : ST_RUN;
                    end
                end
            endcase
        end
    end

    // Run pointer, timeout timer, saturating cycle count and failure record.
    always_ff @(posedge clock) begin
        if (reset || clr || run_init) begin
            rd_ptr        <= '0;
            timer         <= '0;
            cycles        <= '0;
            fail_code_reg <= FC_NONE;
            fail_idx      <= '0;
        end else if (state == ST_RUN) begin
            if (cycles != '1) begin
                cycles <= cycles + 32'd1;
            end
            if (advance) begin
                rd_ptr <= rd_ptr + IDX_W'(1);
                timer  <= '0;
            end else begin
                timer <= timer + TMR_W'(1);
            end
            if (state_nxt == ST_FAIL) begin
                fail_code_reg <= fail_code_nxt;
                fail_idx      <= rd_ptr;
            end
        end
    end

endmodule
